boot_loader_seq: RTL and testbench

Boot-time copy sequencer between the SPI-flash boot ROM interface and the internal boot RAM. After reset it reads an image header from flash, copies the image word by word into boot RAM, and holds the RISC-V core in reset until the copy completes. It is the only master of the boot ROM read port and the boot RAM write port during boot.

---
 rtl/boot_loader_seq.sv | 272 +++++++++++++++++++++++++++
 tb/tb_boot_loader_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_seq.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader_seq
// Brief    : Copies a length-prefixed boot image from the flash ROM read port
//            into boot RAM and holds the core in reset until the copy is done.
//            Define BOOT_CHECKSUM_EN to verify a trailing 32-bit sum word.
// Revision : 1.0  initial release
// ============================================================================
module boot_loader_seq #(
    parameter logic [31:0] FLASH_BASE     = 32'h0000_0000,
    parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
    parameter int          MAX_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_start,
    output logic        rom_rd_en,
    output logic [31:0] rom_rd_addr,
    input  logic        rom_rd_valid,
    input  logic [31:0] rom_rd_data,
    output logic        ram_wr_en,
    output logic [31:0] ram_wr_addr,
    output logic [31:0] ram_wr_data,
    output logic        core_rst,
    output logic        boot_done,
    output logic        boot_err,
    output logic [1:0]  err_code
);

    localparam int          c_IDX_W    = $clog2(MAX_WORDS + 1);
    localparam int          c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_MAX_W32  = 32'(MAX_WORDS);
    localparam logic [1:0]  c_ERR_NONE = 2'd0;
    localparam logic [1:0]  c_ERR_LEN  = 2'd1;
    localparam logic [1:0]  c_ERR_TMO  = 2'd2;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [1:0]  c_ERR_CSUM = 2'd3;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
`ifdef BOOT_CHECKSUM_EN
        , ST_CSUM = 3'd4
`endif
    } state_t;

    state_t               r_state, w_state;
    logic                 r_rom_rd_en, w_rom_rd_en;
    logic [31:0]          r_rom_rd_addr, w_rom_rd_addr;
    logic                 r_ram_wr_en, w_ram_wr_en;
    logic [31:0]          r_ram_wr_addr, w_ram_wr_addr;
    logic [31:0]          r_ram_wr_data, w_ram_wr_data;
    logic                 r_core_rst, w_core_rst;
    logic                 r_boot_done, w_boot_done;
    logic                 r_boot_err, w_boot_err;
    logic [1:0]           r_err_code, w_err_code;
    logic [c_IDX_W-1:0]   r_idx, w_idx;
    logic [c_IDX_W-1:0]   r_len, w_len;
    logic [c_TMO_W-1:0]   r_tmo, w_tmo;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]          r_sum, w_sum;
`endif

    logic                 w_in_read;
    logic                 w_rd_hit;
    logic [c_IDX_W-1:0]   w_idx_inc;
    logic [31:0]          w_next_rd_addr;

    assign w_rd_hit  = r_rom_rd_en & rom_rd_valid;
    assign w_idx_inc = r_idx + 1'b1;
    // Word k of the image body sits one word past the header: FLASH_BASE + 4*(k+1).
    // With k = i+1 this also lands on the checksum word once i+1 == N.
    assign w_next_rd_addr = FLASH_BASE + ((32'(w_idx_inc) + 32'd1) << 2);

`ifdef BOOT_CHECKSUM_EN
    assign w_in_read = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CSUM);
`else
    assign w_in_read = (r_state == ST_HDR) || (r_state == ST_DATA);
`endif

    always_comb begin
        w_state       = r_state;
        w_rom_rd_en   = 1'b0;
        w_rom_rd_addr = r_rom_rd_addr;
        w_ram_wr_en   = 1'b0;
        w_ram_wr_addr = r_ram_wr_addr;
        w_ram_wr_data = r_ram_wr_data;
        w_core_rst    = 1'b1;
        w_boot_done   = 1'b0;
        w_boot_err    = 1'b0;
        w_err_code    = r_err_code;
        w_idx         = r_idx;
        w_len         = r_len;
        w_tmo         = r_tmo;
`ifdef BOOT_CHECKSUM_EN
        w_sum         = r_sum;
`endif

        case (r_state)
            ST_IDLE: begin
                w_state       = ST_HDR;
                w_rom_rd_en   = 1'b1;
                w_rom_rd_addr = FLASH_BASE;
                w_tmo         = '0;
                w_err_code    = c_ERR_NONE;
            end

            ST_HDR: begin
                if (w_rd_hit) begin
                    if ((rom_rd_data == 32'd0) || (rom_rd_data > c_MAX_W32)) begin
                        w_state    = ST_ERROR;
                        w_boot_err = 1'b1;
                        w_err_code = c_ERR_LEN;
                    end else begin
                        w_state       = ST_DATA;
                        w_len         = rom_rd_data[c_IDX_W-1:0];
                        w_idx         = '0;
`ifdef BOOT_CHECKSUM_EN
                        w_sum         = '0;
`endif
                        w_rom_rd_en   = 1'b1;
                        w_rom_rd_addr = FLASH_BASE + 32'd4;
                        w_tmo         = '0;
                    end
                end
            end

            ST_DATA: begin
                if (w_rd_hit) begin
                    w_state       = ST_WRITE;
                    w_ram_wr_en   = 1'b1;
                    w_ram_wr_addr = RAM_BASE + (32'(r_idx) << 2);
                    w_ram_wr_data = rom_rd_data;
                end
            end

            ST_WRITE: begin
                w_idx = w_idx_inc;
`ifdef BOOT_CHECKSUM_EN
                w_sum = r_sum + r_ram_wr_data;
`endif
                if (w_idx_inc == r_len) begin
`ifdef BOOT_CHECKSUM_EN
                    w_state       = ST_CSUM;
                    w_rom_rd_en   = 1'b1;
                    w_rom_rd_addr = w_next_rd_addr;
                    w_tmo         = '0;
`else
                    w_state     = ST_DONE;
                    w_core_rst  = 1'b0;
                    w_boot_done = 1'b1;
`endif
                end else begin
                    w_state       = ST_DATA;
                    w_rom_rd_en   = 1'b1;
                    w_rom_rd_addr = w_next_rd_addr;
                    w_tmo         = '0;
                end
            end

`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (w_rd_hit) begin
                    if (rom_rd_data == r_sum) begin
                        w_state     = ST_DONE;
                        w_core_rst  = 1'b0;
                        w_boot_done = 1'b1;
                    end else begin
                        w_state    = ST_ERROR;
                        w_boot_err = 1'b1;
                        w_err_code = c_ERR_CSUM;
                    end
                end
            end
`endif

            ST_DONE: begin
                w_core_rst  = 1'b0;
                w_boot_done = 1'b1;
                if (boot_start) begin
                    w_state     = ST_IDLE;
                    w_core_rst  = 1'b1;
                    w_boot_done = 1'b0;
                end
            end

            ST_ERROR: begin
                w_boot_err = 1'b1;
                if (boot_start) begin
                    w_state    = ST_IDLE;
                    w_boot_err = 1'b0;
                    w_err_code = c_ERR_NONE;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // Shared wait handling for every read state; a valid on the final
        // budget cycle is taken as a hit above and never reaches this branch.
        if (w_in_read && !w_rd_hit) begin
            if (r_tmo == c_TMO_LAST) begin
                w_state    = ST_ERROR;
                w_boot_err = 1'b1;
                w_err_code = c_ERR_TMO;
            end else begin
                w_rom_rd_en = 1'b1;
                w_tmo       = r_tmo + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rom_rd_en   <= 1'b0;
            r_rom_rd_addr <= '0;
            r_ram_wr_en   <= 1'b0;
            r_ram_wr_addr <= '0;
            r_ram_wr_data <= '0;
            r_core_rst    <= 1'b1;
            r_boot_done   <= 1'b0;
            r_boot_err    <= 1'b0;
            r_err_code    <= c_ERR_NONE;
            r_idx         <= '0;
            r_len         <= '0;
            r_tmo         <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum         <= '0;
`endif
        end else begin
            r_state       <= w_state;
            r_rom_rd_en   <= w_rom_rd_en;
            r_rom_rd_addr <= w_rom_rd_addr;
            r_ram_wr_en   <= w_ram_wr_en;
            r_ram_wr_addr <= w_ram_wr_addr;
            r_ram_wr_data <= w_ram_wr_data;
            r_core_rst    <= w_core_rst;
            r_boot_done   <= w_boot_done;
            r_boot_err    <= w_boot_err;
            r_err_code    <= w_err_code;
            r_idx         <= w_idx;
            r_len         <= w_len;
            r_tmo         <= w_tmo;
`ifdef BOOT_CHECKSUM_EN
            r_sum         <= w_sum;
`endif
        end
    end

    assign rom_rd_en   = r_rom_rd_en;
    assign rom_rd_addr = r_rom_rd_addr;
    assign ram_wr_en   = r_ram_wr_en;
    assign ram_wr_addr = r_ram_wr_addr;
    assign ram_wr_data = r_ram_wr_data;
    assign core_rst    = r_core_rst;
    assign boot_done   = r_boot_done;
    assign boot_err    = r_boot_err;
    assign err_code    = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_loader_seq
// Brief    : Scoreboard bench for boot_loader_seq with a reactive flash model.
// Revision : 1.0  initial release
// ============================================================================
module tb_boot_loader_seq;

    localparam int          c_TMO  = 64;
    localparam logic [31:0] c_NONE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        boot_start = 1'b0;
    logic        rom_rd_en;
    logic [31:0] rom_rd_addr;
    logic        rom_rd_valid = 1'b0;
    logic [31:0] rom_rd_data = 32'd0;
    logic        ram_wr_en;
    logic [31:0] ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic        core_rst;
    logic        boot_done;
    logic        boot_err;
    logic [1:0]  err_code;

    boot_loader_seq #(
        .FLASH_BASE     (32'h0000_0000),
        .RAM_BASE       (32'h0000_0000),
        .MAX_WORDS      (1024),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .boot_start   (boot_start),
        .rom_rd_en    (rom_rd_en),
        .rom_rd_addr  (rom_rd_addr),
        .rom_rd_valid (rom_rd_valid),
        .rom_rd_data  (rom_rd_data),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .core_rst     (core_rst),
        .boot_done    (boot_done),
        .boot_err     (boot_err),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] flash [0:2047];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] stall_addr = c_NONE;
    int          wcnt     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Flash responds L cycles after the request is first seen; stall_addr never answers.
    always @(negedge clk) begin
        if (rom_rd_valid) begin
            rom_rd_valid = 1'b0;
            wcnt = (rom_rd_en && !rst) ? 1 : 0;
        end else if (rom_rd_en && !rst) begin
            wcnt = wcnt + 1;
            if (wcnt > lat && rom_rd_addr != stall_addr) begin
                rom_rd_valid = 1'b1;
                rom_rd_data  = flash[rom_rd_addr[12:2]];
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write must match the head of the expected queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (ram_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%h data=%h expected=none", ram_wr_addr, ram_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", ram_wr_addr, e.addr);
                    check("wr_data", ram_wr_data, e.data);
                end
            end
        end
    end

    task automatic expect_copy(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({32'(4 * i), flash[i + 1]});
    endtask

    task automatic set_csum(input int n);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 1; i <= n; i++) s = s + flash[i];
        flash[n + 1] = s;
    endtask

    task automatic pulse_start();
        boot_start = 1'b1;
        @(negedge clk);
        boot_start = 1'b0;
    endtask

    task automatic wait_rd(input logic [31:0] a);
        int n;
        n = 0;
        while (!(rom_rd_en === 1'b1 && rom_rd_addr === a) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rd_seen", 32'(rom_rd_en === 1'b1 && rom_rd_addr === a), 32'd1);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(boot_done === 1'b1 || boot_err === 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("end_reached", 32'(boot_done === 1'b1 || boot_err === 1'b1), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_rd_en",   32'(rom_rd_en),   32'd0);
        check("rst_rd_addr", rom_rd_addr,      32'd0);
        check("rst_wr_en",   32'(ram_wr_en),   32'd0);
        check("rst_wr_addr", ram_wr_addr,      32'd0);
        check("rst_wr_data", ram_wr_data,      32'd0);
        check("rst_core",    32'(core_rst),    32'd1);
        check("rst_done",    32'(boot_done),   32'd0);
        check("rst_err",     32'(boot_err),    32'd0);
        check("rst_code",    32'(err_code),    32'd0);
    endtask

    task automatic check_done(input string nm);
        check({nm, "_done"}, 32'(boot_done), 32'd1);
        check({nm, "_core"}, 32'(core_rst),  32'd0);
        check({nm, "_err"},  32'(boot_err),  32'd0);
        check({nm, "_qe"},   32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_err(input string nm, input logic [1:0] code);
        check({nm, "_err"},  32'(boot_err),  32'd1);
        check({nm, "_code"}, 32'(err_code),  32'(code));
        check({nm, "_core"}, 32'(core_rst),  32'd1);
        check({nm, "_done"}, 32'(boot_done), 32'd0);
        check({nm, "_qe"},   32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int i = 0; i < 2048; i++) flash[i] = 32'd0;

        // Reset state, then N=4 copy with a boot_start ignored mid-copy
        repeat (3) @(negedge clk);
        check_reset_vals();
        flash[0] = 32'd4;
        flash[1] = 32'h11; flash[2] = 32'h22; flash[3] = 32'h33; flash[4] = 32'h44;
        flash[5] = 32'hAA;
        lat = 1;
        expect_copy(4);
        rst = 1'b0;
        wait_rd(32'h8);
        pulse_start();
        wait_end();
        check_done("n4");
        check("n4_code", 32'(err_code), 32'd0);

        // Re-boot from DONE with latency 2
        lat = 2;
        expect_copy(4);
        pulse_start();
        check("reboot_core", 32'(core_rst),  32'd1);
        check("reboot_done", 32'(boot_done), 32'd0);
        wait_end();
        check_done("reboot");

        // Bad length N=0 via reset, then N=1025 via re-boot from ERROR
        flash[0] = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_end();
        check_err("len0", 2'd1);
        flash[0] = 32'd1025;
        pulse_start();
        check("errclr_err",  32'(boot_err), 32'd0);
        check("errclr_code", 32'(err_code), 32'd0);
        wait_end();
        check_err("len1025", 2'd1);

        // N=1 with valid arriving on the last timeout cycle: valid wins
        flash[0] = 32'd1;
        flash[1] = 32'h5A5A_5A5A;
        flash[2] = 32'h5A5A_5A5A;
        lat = c_TMO - 1;
        expect_copy(1);
        pulse_start();
        wait_end();
        check_done("edge_tmo");

        // Word 2 never answers: timeout exactly c_TMO cycles after request
        flash[0] = 32'd3;
        flash[1] = 32'hA1; flash[2] = 32'hA2; flash[3] = 32'hA3;
        lat = 1;
        stall_addr = 32'h8;
        exp_q.push_back({32'h0, 32'hA1});
        pulse_start();
        wait_rd(32'h8);
        t0 = cyc;
        wait_end();
        check("tmo_cycles", 32'(cyc - t0), 32'(c_TMO));
        check("tmo_rd_en",  32'(rom_rd_en), 32'd0);
        check_err("tmo", 2'd2);
        stall_addr = c_NONE;

        // Asynchronous reset during the third word of an N=8 copy
        flash[0] = 32'd8;
        for (int i = 1; i <= 8; i++) flash[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
        set_csum(8);
        expect_copy(2);
        pulse_start();
        wait_rd(32'hC);
        rst = 1'b1;
        #1;
        check_reset_vals();
        check("midrst_qe", 32'(exp_q.size()), 32'd0);
        expect_copy(8);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_rd(32'h0);
        wait_end();
        check_done("restart");

        // Checksum wrap: 0xFFFFFFFF + 2 = 1
        flash[0] = 32'd2;
        flash[1] = 32'hFFFF_FFFF;
        flash[2] = 32'h2;
        flash[3] = 32'h1;
        expect_copy(2);
        pulse_start();
        wait_end();
        check_done("csum_ok");
        flash[3] = 32'h2;
        expect_copy(2);
        pulse_start();
        wait_end();
`ifdef BOOT_CHECKSUM_EN
        check_err("csum_bad", 2'd3);
`else
        check_done("csum_off");
`endif

        repeat (3) @(negedge clk);
        check("final_qe", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
